// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, instruction register, valid/ready issue
// Optional single-step mode via FETCH_CTRL_SSTEP_EN (adds STEP input).
module fetch_ctrl #(
  parameter int              PC_W     = 4,
  parameter int              INS_W    = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [2:0]      OP_HALT  = 3'b011,
  parameter logic [2:0]      OP_JMP   = 3'b101,
  parameter logic [2:0]      OP_BRZ   = 3'b100
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
`ifdef FETCH_CTRL_SSTEP_EN
  input  logic             STEP,
`endif
  output logic [PC_W-1:0]  PC,
  input  logic [INS_W-1:0] RES_INS,
  input  logic             ZERO,
  output logic [INS_W-1:0] IR,
  output logic             IR_VALID,
  input  logic             EX_READY,
  output logic             HALTED
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t          state, state_d;
  logic [PC_W-1:0] pc, pc_next;
  logic [INS_W-1:0] ir;
  logic            ir_valid, halted;
  logic            start, load_ir, fetch_halt, accept, single_step;
  logic [2:0]      ir_op;

`ifdef FETCH_CTRL_SSTEP_EN
  logic step_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) step_q <= 1'b0;
    else        step_q <= STEP;
  end

  assign start       = EN & STEP & ~step_q;
  assign single_step = 1'b1;
`else
  assign start       = EN;
  assign single_step = 1'b0;
`endif

  assign ir_op = ir[INS_W-1 -: 3];

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (ir_op == OP_JMP || (ir_op == OP_BRZ && ZERO)) pc_next = ir[PC_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  // RES_INS is only looked at in FETCH so an unknown memory word cannot leak elsewhere.
  always_comb begin
    state_d    = state;
    load_ir    = 1'b0;
    fetch_halt = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        load_ir = 1'b1;
        if (RES_INS[INS_W-1 -: 3] == OP_HALT) begin
          fetch_halt = 1'b1;
          state_d    = HALT;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: if (EX_READY) begin
        accept  = 1'b1;
        state_d = (EN && !single_step) ? FETCH : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (load_ir) begin
        ir       <= RES_INS;
        ir_valid <= ~fetch_halt;
      end
      if (fetch_halt) halted <= 1'b1;
      if (accept) begin
        ir_valid <= 1'b0;
        pc       <= pc_next;
      end
    end
  end

  assign PC       = pc;
  assign IR       = ir;
  assign IR_VALID = ir_valid;
  assign HALTED   = halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, EN, ZERO, EX_READY;
  logic [3:0]  PC;
  logic [10:0] RES_INS, IR;
  logic        IR_VALID, HALTED;
`ifdef FETCH_CTRL_SSTEP_EN
  logic        STEP;
`endif

  logic [10:0] mem [16];
  assign RES_INS = mem[PC];

  typedef struct {
    logic [3:0]  pc;
    logic [10:0] ir;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
`ifdef FETCH_CTRL_SSTEP_EN
    .STEP(STEP),
`endif
    .PC(PC), .RES_INS(RES_INS), .ZERO(ZERO), .IR(IR),
    .IR_VALID(IR_VALID), .EX_READY(EX_READY), .HALTED(HALTED)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] pc);
    exp_t e;
    e.pc = pc;
    e.ir = mem[pc];
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for IR_VALID, then pops the scoreboard and checks PC/IR.
  task automatic wait_issue(input string tag, output int lat, output exp_t e);
    lat = 0;
    while (IR_VALID !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, 32'(IR_VALID), 32'd1);
    e = exp_q.pop_front();
    chk({tag, "_pc"}, 32'(PC), 32'(e.pc));
    chk({tag, "_ir"}, 32'(IR), 32'(e.ir));
  endtask

  task automatic handshake(input logic z);
    ZERO     = z;
    EX_READY = 1'b1;
    tick();
    EX_READY = 1'b0;
    ZERO     = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [3:0] pc, input logic z,
                       input logic [3:0] exp_next);
    int   lat;
    exp_t e;
    push(pc);
    wait_issue(tag, lat, e);
    handshake(z);
    chk({tag, "_next_pc"}, 32'(PC), 32'(exp_next));
  endtask

  initial begin
    int   lat;
    exp_t e;
    for (int i = 0; i < 16; i++) mem[i] = 11'b00000000000;
    RST_N = 1'b0; EN = 1'b0; ZERO = 1'b0; EX_READY = 1'b0;
`ifdef FETCH_CTRL_SSTEP_EN
    STEP = 1'b0;
`endif
    tick();
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_ir", 32'(IR), 32'd0);
    chk("rst_valid", 32'(IR_VALID), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);

`ifdef FETCH_CTRL_SSTEP_EN
    RST_N = 1'b1; EN = 1'b1; EX_READY = 1'b1;
    for (int s = 0; s < 3; s++) begin
      STEP = 1'b1; tick(); tick(); tick(); tick();
      STEP = 1'b0; tick(); tick(); tick();
      chk("sstep_pc", 32'(PC), 32'(s + 1));
      chk("sstep_idle_valid", 32'(IR_VALID), 32'd0);
    end
    for (int i = 0; i < 6; i++) tick();
    chk("sstep_total_pc", 32'(PC), 32'd3);
`else
    mem[0] = 11'b01000000110;
    mem[1] = 11'b01000011101;
    mem[2] = 11'b10100000110;
    mem[6] = 11'b10001010001;
    mem[7] = 11'b00011110000;
    mem[8] = 11'b10100000011;
    mem[3] = 11'b01100000000;
    RST_N = 1'b1; EN = 1'b1;

    push(4'd0);
    wait_issue("w0", lat, e);
    chk("first_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(IR_VALID), 32'd1);
      chk("stall_pc", 32'(PC), 32'd0);
      chk("stall_ir", 32'(IR), 32'(e.ir));
    end
    handshake(1'b0);
    chk("stall_next_pc", 32'(PC), 32'd1);

    push(4'd1);
    wait_issue("w1", lat, e);
    chk("second_latency", 32'(lat), 32'd1);
    handshake(1'b0);
    chk("w1_next_pc", 32'(PC), 32'd2);

    issue("jmp6_a", 4'd2, 1'b0, 4'd6);
    issue("brz_taken", 4'd6, 1'b1, 4'd1);
    issue("w1_again", 4'd1, 1'b0, 4'd2);
    issue("jmp6_b", 4'd2, 1'b0, 4'd6);
    issue("brz_not", 4'd6, 1'b0, 4'd7);
    issue("w7", 4'd7, 1'b0, 4'd8);
    issue("jmp3", 4'd8, 1'b0, 4'd3);

    tick();
    chk("halt_flag", 32'(HALTED), 32'd1);
    chk("halt_valid", 32'(IR_VALID), 32'd0);
    for (int i = 0; i < 20; i++) begin
      EN = 1'($urandom_range(1)); EX_READY = 1'($urandom_range(1));
      tick();
      chk("halt_pc_hold", 32'(PC), 32'd3);
      chk("halt_valid_hold", 32'(IR_VALID), 32'd0);
    end
    EX_READY = 1'b0;
    chk("halt_sticky", 32'(HALTED), 32'd1);

    RST_N = 1'b0; EN = 1'b1;
    #1;
    chk("halt_rst_pc", 32'(PC), 32'd0);
    chk("halt_rst_flag", 32'(HALTED), 32'd0);
    mem[0]  = 11'b10100001111;
    mem[15] = 11'b01011110000;
    mem[4]  = 11'b00100000100;
    mem[5]  = 11'b01000000101;
    tick();
    RST_N = 1'b1;

    issue("jmp15", 4'd0, 1'b0, 4'd15);
    mem[0] = 11'b10100000100;
    issue("wrap", 4'd15, 1'b0, 4'd0);
    issue("jmp4", 4'd0, 1'b0, 4'd4);

    push(4'd4);
    wait_issue("en_drop", lat, e);
    EN = 1'b0;
    tick();
    chk("en_drop_hold", 32'(IR_VALID), 32'd1);
    handshake(1'b0);
    chk("en_drop_pc", 32'(PC), 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 32'(IR_VALID), 32'd0);
      chk("idle_pc", 32'(PC), 32'd5);
    end
    EN = 1'b1;
    push(4'd5);
    wait_issue("resume", lat, e);

    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(IR_VALID), 32'd0);
    chk("async_rst_pc", 32'(PC), 32'd0);
    tick();
    RST_N = 1'b1;
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
